// File: rtl/reduction_pkg.sv
// Shared constants and helpers for the reduction pipeline.
package reduction_pkg;

   localparam int W_DEFAULT = 16;
   localparam int N_DEFAULT = 8;

   // Ceiling log2, usable in constant expressions (clog2(1) = 0).
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res++;
         v = v >>> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/adder_sw_bit.sv
// Plain SW-bit unsigned adder used by every reduction stage.
module adder_sw_bit #(
   parameter int SW = 19
) (
   input  logic [SW-1:0] a_i,
   input  logic [SW-1:0] b_i,
   output logic [SW-1:0] sum_o
);

   // SW is sized so that the largest reachable partial sum always fits,
   // so the top carry can never be lost here.
   assign sum_o = a_i + b_i;

endmodule

// File: rtl/reduction_unit_pipe.sv
// Linear N-1 stage pipeline summing N unsigned W-bit operands with a
// global stall (en), per-transaction saturate/wrap result and overflow flag.
module reduction_unit_pipe
   import reduction_pkg::*;
#(
   parameter  int W  = W_DEFAULT,
   parameter  int N  = N_DEFAULT,
   localparam int SW = W + clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*W-1:0] p_flat,
   input  logic           sat_en,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [SW-1:0]  full_sum,
   output logic [W-1:0]   result,
   output logic           ovf
);

   localparam int PAD = SW - W;

   logic         en;
   logic [N-1:1] valid_q, valid_d;
   logic [N-1:1] sat_q, sat_d;

   // The whole pipeline moves together; it only freezes behind an unaccepted result.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Next state of the per-stage valid and mode bits: shift by one stage when enabled.
   always_comb begin
      // NOTE: defaults first so every path assigns both vectors and no latch is inferred.
      valid_d = valid_q;
      sat_d   = sat_q;
      if (en) begin
         valid_d[1] = in_valid;
         sat_d[1]   = sat_en;
         for (int k = 2; k < N; k++) begin
            valid_d[k] = valid_q[k-1];
            sat_d[k]   = sat_q[k-1];
         end
      end
   end

   // Valid and mode bits clear asynchronously so in-flight work is discarded at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         sat_q   <= '0;
      end else begin
         // NOTE: non-blocking assignment so every register samples pre-edge values.
         valid_q <= valid_d;
         sat_q   <= sat_d;
      end
   end

   // Stage k adds operand k to the running sum of stage k-1. Operands not yet
   // consumed ride along in a shrinking skew array (operands k+1..N-1 at stage k).
   for (genvar k = 1; k < N; k++) begin : g_stage
      logic [SW-1:0] op_a;
      logic [SW-1:0] op_b;
      logic [SW-1:0] sum;
      logic [SW-1:0] sum_q;
      logic          load;

      if (k == 1) begin : g_src
         assign op_a = {{PAD{1'b0}}, p_flat[0 +: W]};
         assign op_b = {{PAD{1'b0}}, p_flat[W +: W]};
         assign load = en && in_valid;
      end else begin : g_src
         assign op_a = g_stage[k-1].sum_q;
         assign op_b = {{PAD{1'b0}}, g_stage[k-1].g_skew.skew_q[k]};
         assign load = en && valid_q[k-1];
      end

      adder_sw_bit #(.SW(SW)) u_add (
         .a_i   (op_a),
         .b_i   (op_b),
         .sum_o (sum)
      );

      if (k == N-1) begin : g_reg
         // Output stage sum is architecturally visible, so it resets to zero.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)    sum_q <= '0;
            else if (load) sum_q <= sum;
         end
      end else begin : g_reg
         // Internal partial sum; captured only when a real transaction arrives.
         // NOTE: no reset on datapath storage; the valid bits alone decide what is live.
         always_ff @(posedge clk) begin
            if (load) sum_q <= sum;
         end
      end

      if (k < N-1) begin : g_skew
         logic [W-1:0] skew_q [k+1:N-1];

         if (k == 1) begin : g_load
            // Capture the operands for all later stages at acceptance.
            always_ff @(posedge clk) begin
               if (load) begin
                  for (int j = k + 1; j < N; j++) skew_q[j] <= p_flat[j*W +: W];
               end
            end
         end else begin : g_load
            // Forward the operands not yet consumed from the previous stage.
            always_ff @(posedge clk) begin
               if (load) begin
                  for (int j = k + 1; j < N; j++) skew_q[j] <= g_stage[k-1].g_skew.skew_q[j];
               end
            end
         end
      end
   end

   assign out_valid = valid_q[N-1];
   assign full_sum  = g_stage[N-1].sum_q;
   assign ovf       = |full_sum[SW-1:W];
   assign result    = (sat_q[N-1] && ovf) ? {W{1'b1}} : full_sum[W-1:0];

endmodule

// File: tb/tb_reduction_unit_pipe.sv
// Self-checking bench: table vectors, directed corner sequences and random
// traffic against a queue-based arithmetic reference model.
module tb_reduction_unit_pipe;
   import reduction_pkg::*;

   localparam int W  = 16;
   localparam int N  = 8;
   localparam int SW = W + clog2(N);
   localparam int LAT = N - 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid, in_ready, sat_en, out_valid, out_ready, ovf;
   logic [N*W-1:0] p_flat;
   logic [SW-1:0]  full_sum;
   logic [W-1:0]   result;

   // Second instance: N=2, W=8
   logic           in_valid2, in_ready2, sat2, out_valid2, out_ready2, ovf2;
   logic [15:0]    p_flat2;
   logic [8:0]     full_sum2;
   logic [7:0]     result2;

   always #5 clk = ~clk;

   reduction_unit_pipe #(.W(W), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .p_flat(p_flat), .sat_en(sat_en), .out_valid(out_valid), .out_ready(out_ready),
      .full_sum(full_sum), .result(result), .ovf(ovf)
   );

   reduction_unit_pipe #(.W(8), .N(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .p_flat(p_flat2), .sat_en(sat2), .out_valid(out_valid2), .out_ready(out_ready2),
      .full_sum(full_sum2), .result(result2), .ovf(ovf2)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { longint sum; bit sat; } exp_t;
   exp_t q[$];

   function automatic longint model_sum(input logic [N*W-1:0] p);
      longint s = 0;
      for (int k = 0; k < N; k++) s += longint'(p[k*W +: W]);
      return s;
   endfunction

   function automatic logic [N*W-1:0] rand_p();
      logic [N*W-1:0] p;
      int mode = $urandom_range(0, 2);
      for (int k = 0; k < N; k++) begin
         case (mode)
            0:       p[k*W +: W] = W'($urandom);
            1:       p[k*W +: W] = ($urandom_range(0, 3) != 0) ? 16'hFFFF : W'($urandom);
            default: p[k*W +: W] = W'($urandom_range(0, 15));
         endcase
      end
      return p;
   endfunction

   // ---------------- cycle driver / scoreboard ----------------
   int            cyc = 0;
   int            acc_cyc, pop_cyc, n_pop = 0;
   bit            popped;
   logic [SW-1:0] pop_fs;
   logic [W-1:0]  pop_res;
   logic          pop_ovf;

   task automatic cycle(input bit iv, input logic [N*W-1:0] p, input bit s, input bit ordy);
      exp_t   e;
      longint lim;
      bit     e_ovf;
      longint e_res;
      @(negedge clk);
      in_valid  = iv;
      p_flat    = p;
      sat_en    = s;
      out_ready = ordy;
      #1;
      cyc++;
      popped = 1'b0;
      if (out_valid && out_ready) begin
         popped  = 1'b1;
         n_pop++;
         pop_cyc = cyc;
         pop_fs  = full_sum;
         pop_res = result;
         pop_ovf = ovf;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected output: got full_sum 0x%0h with no transaction outstanding", full_sum);
         end else begin
            e     = q.pop_front();
            lim   = longint'(1) << W;
            e_ovf = (e.sum >= lim);
            e_res = (e.sat && e_ovf) ? lim - 1 : e.sum % lim;
            check("sb full_sum", 64'(full_sum), 64'(e.sum));
            check("sb result",   64'(result),   64'(e_res));
            check("sb ovf",      64'(ovf),      64'(e_ovf));
         end
      end
      if (iv && in_ready) begin
         q.push_back('{sum: model_sum(p), sat: s});
         acc_cyc = cyc;
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (q.size() != 0 && n < 60) begin
         cycle(1'b0, '0, 1'b0, 1'b1);
         n++;
      end
      check({name, " drained"}, 64'(q.size()), 64'd0);
   endtask

   // single transaction: latency and value check against expected constants
   task automatic single(input string name, input logic [N*W-1:0] p, input bit s,
                         input logic [SW-1:0] e_sum, input logic [W-1:0] e_res, input bit e_ovf);
      int  a;
      bit  got = 1'b0;
      cycle(1'b1, p, s, 1'b1);
      a = acc_cyc;
      for (int i = 0; i < 20 && !got; i++) begin
         cycle(1'b0, '0, 1'b0, 1'b1);
         got = popped;
      end
      check({name, " emerged"}, 64'(got), 64'd1);
      if (got) begin
         check({name, " latency"},  64'(pop_cyc - a), 64'(LAT));
         check({name, " full_sum"}, 64'(pop_fs),  64'(e_sum));
         check({name, " result"},   64'(pop_res), 64'(e_res));
         check({name, " ovf"},      64'(pop_ovf), 64'(e_ovf));
      end
   endtask

   typedef struct {
      string          name;
      logic [N*W-1:0] p;
      bit             sat;
      logic [SW-1:0]  sum;
      logic [W-1:0]   res;
      bit             ovf;
   } vec_t;
   vec_t vecs[8];

   initial begin
      logic [N*W-1:0] p;
      int             first, npl, pops0;
      bit             seen;

      // ---- table of directed vectors ----
      vecs[0] = '{"all_ffff_sat", {N{16'hFFFF}}, 1'b1, 19'h7FFF8, 16'hFFFF, 1'b1};
      vecs[1] = '{"all_ffff_wrap", {N{16'hFFFF}}, 1'b0, 19'h7FFF8, 16'hFFF8, 1'b1};
      vecs[2] = '{"zeros", '0, 1'b1, 19'h0, 16'h0, 1'b0};
      for (int k = 0; k < N; k++) p[k*W +: W] = 16'(k + 1);
      vecs[3] = '{"k_plus_1", p, 1'b0, 19'd36, 16'd36, 1'b0};
      p = '0; p[15:0] = 16'hFFFF; p[31:16] = 16'h0001;
      vecs[4] = '{"exact_2w_sat", p, 1'b1, 19'h10000, 16'hFFFF, 1'b1};
      vecs[5] = '{"exact_2w_wrap", p, 1'b0, 19'h10000, 16'h0000, 1'b1};
      p = '0; p[15:0] = 16'hFFFF;
      vecs[6] = '{"max_no_ovf", p, 1'b1, 19'h0FFFF, 16'hFFFF, 1'b0};
      p = '0; p[127:112] = 16'h8000; p[111:96] = 16'h8000; p[95:80] = 16'h1234;
      vecs[7] = '{"high_ops", p, 1'b0, 19'h11234, 16'h1234, 1'b1};

      // ---- reset ----
      rst_n = 1'b0; in_valid = 1'b0; p_flat = '0; sat_en = 1'b0; out_ready = 1'b0;
      in_valid2 = 1'b0; p_flat2 = '0; sat2 = 1'b0; out_ready2 = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset full_sum",  64'(full_sum),  64'd0);
      check("reset result",    64'(result),    64'd0);
      check("reset ovf",       64'(ovf),       64'd0);
      rst_n = 1'b1;
      #1;
      check("reset in_ready", 64'(in_ready), 64'd1);

      foreach (vecs[i]) single(vecs[i].name, vecs[i].p, vecs[i].sat, vecs[i].sum, vecs[i].res, vecs[i].ovf);

      // ---- 20 back-to-back sets, one result per cycle ----
      for (int k = 0; k < N; k++) p[k*W +: W] = 16'(k + 1);
      npl = 0;
      first = cyc + 1;
      for (int i = 0; i < 45; i++) begin
         cycle(i < 20, p, 1'b0, 1'b1);
         if (popped) begin
            check("b2b pop cycle", 64'(pop_cyc), 64'(first + LAT + npl));
            check("b2b full_sum",  64'(pop_fs),  64'd36);
            npl++;
         end
      end
      check("b2b count", 64'(npl), 64'd20);

      // ---- stall with full pipeline ----
      for (int i = 0; i < 10; i++) cycle(1'b1, rand_p(), 1'($urandom), 1'b1);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, rand_p(), 1'($urandom), 1'b0);
         check("stall in_ready",  64'(in_ready),  64'd0);
         check("stall out_valid", 64'(out_valid), 64'd1);
         check("stall frozen full_sum", 64'(full_sum), 64'(q[0].sum));
      end
      drain("stall");

      // ---- random traffic ----
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, rand_p(), 1'($urandom), $urandom_range(0, 3) != 0);
      drain("random");

      // ---- asynchronous reset with 4 in flight ----
      for (int i = 0; i < 4; i++) cycle(1'b1, {N{16'hFFFF}}, 1'b1, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle(1'b0, '0, 1'b0, 1'b0);
         seen = out_valid;
      end
      check("pre-reset out_valid", 64'(seen), 64'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async reset out_valid", 64'(out_valid), 64'd0);
      check("async reset full_sum",  64'(full_sum),  64'd0);
      check("async reset ovf",       64'(ovf),       64'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      pops0 = n_pop;
      for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b0, 1'b1);
      check("post-reset no ghosts", 64'(n_pop - pops0), 64'd0);
      single("post_reset", vecs[3].p, 1'b0, 19'd36, 16'd36, 1'b0);

      // ---- N=2, W=8 instance ----
      @(negedge clk);
      in_valid2 = 1'b1; p_flat2 = 16'h01FF; sat2 = 1'b1; out_ready2 = 1'b1;
      @(negedge clk);
      in_valid2 = 1'b1; sat2 = 1'b0;
      #1;
      check("n2 out_valid", 64'(out_valid2), 64'd1);
      check("n2 full_sum",  64'(full_sum2),  64'h100);
      check("n2 ovf",       64'(ovf2),       64'd1);
      check("n2 result sat", 64'(result2),   64'hFF);
      @(negedge clk);
      in_valid2 = 1'b0;
      #1;
      check("n2 result wrap", 64'(result2), 64'h00);
      @(negedge clk);
      #1;
      check("n2 bubble", 64'(out_valid2), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // absolute watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/reduction_unit_pipe.md
REDUCTION_UNIT_PIPE -- requirements
Module: reduction_unit_pipe

Interface
REQ-001 SHALL have parameter W, default 16, meaning partial-product width in bits (W >= 2).
REQ-002 SHALL have parameter N, default 8, meaning number of partial products summed (N >= 2).
REQ-003 SHALL define derived constant SW = W + clog2(N), the full-precision sum width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operand set present.
REQ-007 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-008 SHALL have port p_flat  input  N*W  operands; P[k] = p_flat[k*W +: W].
REQ-009 SHALL have port sat_en  input  1  per-transaction mode: 1 = saturate result, 0 = wrap.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port full_sum  output  SW  exact unsigned sum of all N operands.
REQ-013 SHALL have port result  output  W  W-bit sum per mode.
REQ-014 SHALL have port ovf  output  1  full_sum >= 2^W.

Function
REQ-015 SHALL accept a transaction when in_valid && in_ready; all N operands and sat_en SHALL be sampled in that same cycle.
REQ-016 SHALL implement N-1 pipeline stages; stage k (1..N-1) adds stage k-1 partial sum (stage 0 = P[0]) to P[k], zero-extended to SW bits, no carry dropped.
REQ-017 SHALL carry P[k] and sat_en through skew registers travelling with the transaction until consumed at stage k or the output.
REQ-018 SHALL hold one valid bit per stage; latency from acceptance to out_valid SHALL be exactly N-1 cycles when unstalled.
REQ-019 SHALL sustain one transaction per cycle when out_ready is held high.
REQ-020 SHALL advance the whole pipeline only when en = !out_valid || out_ready; in_ready SHALL equal en.
REQ-021 SHALL hold full_sum, result, ovf, out_valid stable while out_valid && !out_ready.
REQ-022 SHALL NOT lose or duplicate transactions when acceptance and output handshake occur in the same cycle.
REQ-023 SHALL drive result = 2^W-1 when sat_en && ovf, else full_sum[W-1:0].
REQ-024 SHALL compute ovf combinationally from the registered full_sum.
REQ-025 SHALL treat empty pipeline bubbles as invalid; bubble stages SHALL never raise out_valid.

Reset
REQ-026 SHALL, on rst_n low, immediately clear all stage valid bits and out_valid to 0, independent of clk.
REQ-027 SHALL reset full_sum, result, ovf to 0; datapath registers other than valids MAY be non-reset.
REQ-028 SHALL discard all in-flight transactions on reset mid-operation; first accepted transaction after release SHALL emerge after N-1 cycles.

Structure
REQ-029 SHALL place clog2 function and default W/N constants in shared package reduction_pkg.
REQ-030 SHALL instantiate one sub-module adder_sw_bit (parametrised SW-bit unsigned adder, no carry-in) per stage.

Verification
REQ-031 W=16, N=8, all P=0xFFFF, sat_en=1 -> after 7 cycles full_sum=0x7FFF8, ovf=1, result=0xFFFF; same with sat_en=0 -> result=0xFFF8.
REQ-032 P[k]=k+1, sat_en=0, out_ready=1, 20 back-to-back sets -> out_valid high 7 cycles after first accept, each full_sum=36, one result per cycle.
REQ-033 out_ready low 5 cycles with pipeline full -> in_ready low, outputs frozen, no loss; ordering preserved after release.
REQ-034 rst_n asserted asynchronously with 4 transactions in flight -> out_valid=0 before next clk edge; none emerges after release.
REQ-035 N=2, W=8, P0=0xFF, P1=0x01, sat_en=1 -> 1 cycle later full_sum=0x100, ovf=1, result=0xFF.
